palette_arbiter: RTL and testbench

PALETTE_ARBITER -- requirements
Module: palette_arbiter

---
 rtl/palette_arbiter_pkg.sv | 13 +
 rtl/palette_arbiter_color_decoder.sv | 36 +++
 rtl/palette_arbiter.sv | 79 +++++++
 tb/tb_palette_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/palette_arbiter_pkg.sv
// Shared palette constants and helpers for the two-player sprite pixel arbiter.
package palette_arbiter_pkg;

    localparam logic [3:0]  IDX_TRANSPARENT = 4'd0;
    localparam logic [3:0]  IDX_LAST_LEGAL  = 4'd10;
    localparam logic [11:0] RGB_TRANSPARENT = 12'h000;
    localparam logic [11:0] RGB_ERROR       = 12'hF0F;

    function automatic logic idx_illegal(input logic [3:0] idx);
        return idx > IDX_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/palette_arbiter_color_decoder.sv
// Combinational palette lookup: 4-bit color index plus team select to 12-bit RGB.
module palette_arbiter_color_decoder
    import palette_arbiter_pkg::*;
(
    input  logic [3:0]  index,
    input  logic        is_b,
    output logic [11:0] rgb,
    output logic        transparent,
    output logic        illegal
);

    always_comb begin
        rgb         = RGB_ERROR;
        transparent = 1'b0;
        illegal     = idx_illegal(index);
        case (index)
            IDX_TRANSPARENT: begin
                rgb         = RGB_TRANSPARENT;
                transparent = 1'b1;
            end
            // Only the first two entries are team colored.
            4'd1:    rgb = is_b ? 12'h8DF : 12'hD42;
            4'd2:    rgb = is_b ? 12'h009 : 12'h921;
            4'd3:    rgb = 12'hFF9;
            4'd4:    rgb = 12'h210;
            4'd5:    rgb = 12'h778;
            4'd6:    rgb = 12'h6B4;
            4'd7:    rgb = 12'hDD0;
            4'd8:    rgb = 12'hFFF;
            4'd9:    rgb = 12'h0F0;
            4'd10:   rgb = 12'hBBB;
            default: rgb = RGB_ERROR;
        endcase
    end

endmodule

// File: rtl/palette_arbiter.sv
// Round-robin arbiter between two sprite pixel paths feeding one shared palette
// decoder, with a one-entry registered output stage and an illegal-index counter.
module palette_arbiter
    import palette_arbiter_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_index,
    input  logic             req0_is_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_index,
    input  logic             req1_is_b,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_rgb,
    output logic             out_src,
    output logic             out_transparent,
    output logic [ERR_W-1:0] err_count
);

    logic        last_grant;
    logic        can_accept;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [3:0]  sel_index;
    logic        sel_is_b;
    logic [11:0] dec_rgb;
    logic        dec_transparent;
    logic        dec_illegal;

    assign can_accept = !out_valid || out_ready;

    // On contention the requester that did not win last time goes first.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = grant0 && can_accept && !rst;
    assign req1_ready = grant1 && can_accept && !rst;
    assign accept     = req0_ready || req1_ready;

    assign sel_index = grant1 ? req1_index : req0_index;
    assign sel_is_b  = grant1 ? req1_is_b  : req0_is_b;

    palette_arbiter_color_decoder u_color_decoder (
        .index       (sel_index),
        .is_b        (sel_is_b),
        .rgb         (dec_rgb),
        .transparent (dec_transparent),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_rgb         <= RGB_TRANSPARENT;
            out_src         <= 1'b0;
            out_transparent <= 1'b0;
            err_count       <= '0;
            last_grant      <= 1'b1;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_rgb         <= dec_rgb;
            out_src         <= grant1;
            out_transparent <= dec_transparent;
            last_grant      <= grant1;
            if (dec_illegal && (err_count != {ERR_W{1'b1}}))
                err_count <= err_count + ERR_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed bench for palette_arbiter: reset, palette, contention, backpressure,
// saturating error counter and asynchronous reset mid-stream.
module tb_palette_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [3:0]  req0_index;
    logic        req0_is_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_index;
    logic        req1_is_b;
    logic        req1_ready;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_rgb;
    logic        out_src;
    logic        out_transparent;
    logic [1:0]  err_count;

    int tests;
    int fails;

    palette_arbiter #(.ERR_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_valid      (req0_valid),
        .req0_index      (req0_index),
        .req0_is_b       (req0_is_b),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_index      (req1_index),
        .req1_is_b       (req1_is_b),
        .req1_ready      (req1_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_rgb         (out_rgb),
        .out_src         (out_src),
        .out_transparent (out_transparent),
        .err_count       (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [11:0] rgb,
                             input logic src, input logic tr);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".rgb"},   32'(out_rgb),   32'(rgb));
        check({tag, ".src"},   32'(out_src),   32'(src));
        check({tag, ".transp"}, 32'(out_transparent), 32'(tr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req0_valid = 1'b1; req0_index = 4'd3; req0_is_b = 1'b0;
        req1_valid = 1'b0; req1_index = 4'd0; req1_is_b = 1'b0;
        out_ready = 1'b1;

        // reset state, ready suppressed during reset
        #2;
        check_out("reset", 1'b0, 12'h000, 1'b0, 1'b0);
        check("reset.err", 32'(err_count), 32'd0);
        check("reset.rdy0", 32'(req0_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        tick();
        check("idle.valid", 32'(out_valid), 32'd0);

        // palette through requester 1
        req1_valid = 1'b1; req1_index = 4'd1; req1_is_b = 1'b1;
        #1;
        check("pal.rdy1", 32'(req1_ready), 32'd1);
        check("pal.rdy0", 32'(req0_ready), 32'd0);
        tick();
        check_out("pal.idx1b", 1'b1, 12'h8DF, 1'b1, 1'b0);
        req1_index = 4'd0; req1_is_b = 1'b0;
        tick();
        check_out("pal.idx0", 1'b1, 12'h000, 1'b1, 1'b1);
        req1_index = 4'd2; req1_is_b = 1'b1;
        tick();
        check_out("pal.idx2b", 1'b1, 12'h009, 1'b1, 1'b0);
        req1_index = 4'd2; req1_is_b = 1'b0;
        tick();
        check_out("pal.idx2a", 1'b1, 12'h921, 1'b1, 1'b0);
        req1_index = 4'd10;
        tick();
        check_out("pal.idx10", 1'b1, 12'hBBB, 1'b1, 1'b0);
        req1_valid = 1'b0;
        tick();
        check("drain.valid", 32'(out_valid), 32'd0);
        check("pal.err", 32'(err_count), 32'd0);

        // contention: last grant was requester 1, so requester 0 leads
        req0_valid = 1'b1; req0_index = 4'd4; req0_is_b = 1'b0;
        req1_valid = 1'b1; req1_index = 4'd5; req1_is_b = 1'b0;
        #1;
        check("cont.rdy0", 32'(req0_ready), 32'd1);
        check("cont.rdy1", 32'(req1_ready), 32'd0);
        tick();
        check_out("cont.p0", 1'b1, 12'h210, 1'b0, 1'b0);
        check("cont.rdy1b", 32'(req1_ready), 32'd1);
        tick();
        check_out("cont.p1", 1'b1, 12'h778, 1'b1, 1'b0);
        tick();
        check_out("cont.p2", 1'b1, 12'h210, 1'b0, 1'b0);
        tick();
        check_out("cont.p3", 1'b1, 12'h778, 1'b1, 1'b0);

        // backpressure on an FF9 pixel from requester 0
        req0_index = 4'd3;
        tick();
        check_out("bp.load", 1'b1, 12'hFF9, 1'b0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp.rdy0", 32'(req0_ready), 32'd0);
            check("bp.rdy1", 32'(req1_ready), 32'd0);
            tick();
            check_out("bp.hold", 1'b1, 12'hFF9, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.rel.rdy1", 32'(req1_ready), 32'd1);
        tick();
        check_out("bp.next", 1'b1, 12'h778, 1'b1, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("bp.drain", 32'(out_valid), 32'd0);

        // illegal index: counter saturates at 3 with a 2-bit width
        req0_valid = 1'b1; req0_index = 4'd12;
        tick();
        check_out("err.p1", 1'b1, 12'hF0F, 1'b0, 1'b0);
        check("err.cnt1", 32'(err_count), 32'd1);
        tick();
        check("err.rgb2", 32'(out_rgb), 32'hF0F);
        check("err.cnt2", 32'(err_count), 32'd2);
        tick();
        check("err.rgb3", 32'(out_rgb), 32'hF0F);
        check("err.cnt3", 32'(err_count), 32'd3);
        tick();
        check("err.rgb4", 32'(out_rgb), 32'hF0F);
        check("err.cnt4", 32'(err_count), 32'd3);
        tick();
        check("err.rgb5", 32'(out_rgb), 32'hF0F);
        check("err.cnt5", 32'(err_count), 32'd3);

        // asynchronous reset mid-stream, between clock edges
        check("mid.valid.pre", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_out("mid.rst", 1'b0, 12'h000, 1'b0, 1'b0);
        check("mid.rst.err", 32'(err_count), 32'd0);
        check("mid.rst.rdy0", 32'(req0_ready), 32'd0);
        #2;
        rst = 1'b0;
        // last accept before reset was requester 0; reset must restore req0 priority
        req1_valid = 1'b1; req1_index = 4'd7;
        req0_index = 4'd8;
        #1;
        check("post.rdy0", 32'(req0_ready), 32'd1);
        check("post.rdy1", 32'(req1_ready), 32'd0);
        tick();
        check_out("post.p0", 1'b1, 12'hFFF, 1'b0, 1'b0);
        tick();
        check_out("post.p1", 1'b1, 12'hDD0, 1'b1, 1'b0);
        check("post.err", 32'(err_count), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
